// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and default frame constants, used by the
//               receiver, the oversampling clock generator and the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default oversampling ratio (Sample_clock ticks per bit period)
    localparam int DFLT_OVERSAMPLE = 16;
    // Default number of data bits per frame
    localparam int DFLT_DATA_BITS  = 8;

    // Receiver control states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Serial-side and host-side signal bundle of the UART receiver.
//               'slave' is the receiver view, 'master' the environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DFLT_DATA_BITS
) ();

    logic                 Sample_clock;
    logic                 Rx;
    logic [DATA_BITS-1:0] Rx_data;
    logic                 Rx_valid;
    logic                 Framing_error;
    logic                 Rx_busy;

    modport slave (
        input  Sample_clock,
        input  Rx,
        output Rx_data,
        output Rx_valid,
        output Framing_error,
        output Rx_busy
    );

    modport master (
        output Sample_clock,
        output Rx,
        input  Rx_data,
        input  Rx_valid,
        input  Framing_error,
        input  Rx_busy
    );

endinterface : uart_rx_if
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the asynchronous Rx line and
//               rising-edge tick detector for Sample_clock (already in the
//               Sys_clock domain, so it is only registered, not synchronized).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  wire logic Sys_clock,
    input  wire logic reset,
    input  wire logic sample_clock_i,
    input  wire logic rx_i,
    output logic      rxs_o,
    output logic      tick_o
);

    logic rx_meta_q;
    logic rxs_q;
    logic sample_q;
    logic sample_prev_q;

    // Synchronizer flops reset to the idle-high line level; sample history to 0
    always_ff @(posedge Sys_clock or posedge reset) begin
        if (reset) begin
            rx_meta_q     <= 1'b1;
            rxs_q         <= 1'b1;
            sample_q      <= 1'b0;
            sample_prev_q <= 1'b0;
        end else begin
            rx_meta_q     <= rx_i;
            rxs_q         <= rx_meta_q;
            sample_q      <= sample_clock_i;
            sample_prev_q <= sample_q;
        end
    end

    assign rxs_o  = rxs_q;
    assign tick_o = sample_q & ~sample_prev_q;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 serial receiver. Oversampled start detection, mid-bit
//               data sampling, stop-bit check with framing-error reporting
//               and break recovery through WAIT_HIGH.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DFLT_OVERSAMPLE,
    parameter int DATA_BITS  = DFLT_DATA_BITS
) (
    input  wire logic Sys_clock,
    input  wire logic reset,
    uart_rx_if.slave  bus
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    logic rxs;
    logic tick;

    rx_state_e            state_q,    state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [DATA_BITS-1:0] data_q,     data_d;
    logic                 valid_q,    valid_d;
    logic                 ferr_q,     ferr_d;

    uart_rx_sync u_sync (
        .Sys_clock      (Sys_clock),
        .reset          (reset),
        .sample_clock_i (bus.Sample_clock),
        .rx_i           (bus.Rx),
        .rxs_o          (rxs),
        .tick_o         (tick)
    );

    // State, counters, shift register and registered outputs
    always_ff @(posedge Sys_clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    // Next-state and Mealy output decode; everything advances only on a tick
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end
                START: begin
                    if (tick_cnt_q == HALF_LAST) begin
                        // A line back high at mid-start is a glitch, not a frame
                        state_d    = rxs ? IDLE : DATA;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rxs, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == DATA_LAST) begin
                            state_d   = STOP;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        if (rxs) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_HIGH;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                WAIT_HIGH: begin
                    // Hold here through a break so it reports only one error
                    if (rxs) begin
                        state_d    = IDLE;
                        tick_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            endcase
        end
    end

    assign bus.Rx_data       = data_q;
    assign bus.Rx_valid      = valid_q;
    assign bus.Framing_error = ferr_q;
    assign bus.Rx_busy       = (state_q != IDLE);

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Frames are driven as timed
//               waveforms on Rx; received bytes and framing errors are
//               collected by a monitor and compared with expected outcomes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int OS       = 16;
    localparam int TICK_DIV = 4;                      // Sys_clock cycles per tick
    localparam int CLK_P    = 10;
    localparam int BIT      = OS * TICK_DIV * CLK_P;  // one bit period

    logic Sys_clock = 1'b0;
    logic reset     = 1'b1;
    int   sc_cnt    = 0;

    uart_rx_if bus ();

    uart_rx dut (
        .Sys_clock (Sys_clock),
        .reset     (reset),
        .bus       (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Monitor state
    logic [7:0] rx_q[$];
    int         ferr_cnt  = 0;
    int         width_err = 0;
    int         excl_err  = 0;
    logic       prev_v    = 1'b0;
    logic       prev_f    = 1'b0;

    initial forever #(CLK_P/2) Sys_clock = ~Sys_clock;

    // Sample_clock: 2 cycles high, 2 low, changed away from the active edge
    initial begin
        bus.Sample_clock = 1'b0;
        forever begin
            @(negedge Sys_clock);
            sc_cnt = (sc_cnt + 1) % TICK_DIV;
            bus.Sample_clock = (sc_cnt < 2);
        end
    end

    // Collect every output event once per cycle
    always @(negedge Sys_clock) begin
        if (bus.Rx_valid) rx_q.push_back(bus.Rx_data);
        if (bus.Framing_error) ferr_cnt = ferr_cnt + 1;
        if ((bus.Rx_valid && prev_v) || (bus.Framing_error && prev_f)) width_err = width_err + 1;
        if (bus.Rx_valid && bus.Framing_error) excl_err = excl_err + 1;
        prev_v = bus.Rx_valid;
        prev_f = bus.Framing_error;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        bus.Rx = 1'b0;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            bus.Rx = b[i];
            #BIT;
        end
        bus.Rx = stop_ok;
        #BIT;
        bus.Rx = 1'b1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        bus.Rx = 1'b1;
        repeat (5) @(negedge Sys_clock);
        checks++; if (bus.Rx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %0h expected 00", bus.Rx_data); end
        checks++; if (bus.Rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", bus.Rx_valid); end
        checks++; if (bus.Framing_error !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %0b expected 0", bus.Framing_error); end
        checks++; if (bus.Rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", bus.Rx_busy); end
        reset = 1'b0;
        repeat (20) @(negedge Sys_clock);
        checks++; if (bus.Rx_busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %0b expected 0", bus.Rx_busy); end
    endtask

    task automatic test_good_frame();
        int n0 = rx_q.size();
        int f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1);
        #BIT;
        checks++; if (rx_q.size() !== n0 + 1) begin failures++; $display("FAIL good_count: got %0d expected %0d", rx_q.size() - n0, 1); end
        else begin
            checks++; if (rx_q[n0] !== 8'hA5) begin failures++; $display("FAIL good_byte: got %0h expected a5", rx_q[n0]); end
        end
        checks++; if (bus.Rx_data !== 8'hA5) begin failures++; $display("FAIL good_data: got %0h expected a5", bus.Rx_data); end
        checks++; if (ferr_cnt !== f0) begin failures++; $display("FAIL good_ferr: got %0d expected 0", ferr_cnt - f0); end
    endtask

    task automatic test_false_start();
        int n0 = rx_q.size();
        int f0 = ferr_cnt;
        bus.Rx = 1'b0;
        #(4 * TICK_DIV * CLK_P);
        bus.Rx = 1'b1;
        #(2 * BIT);
        checks++; if (bus.Rx_busy !== 1'b0) begin failures++; $display("FAIL false_busy: got %0b expected 0", bus.Rx_busy); end
        checks++; if (rx_q.size() !== n0) begin failures++; $display("FAIL false_valid: got %0d expected 0", rx_q.size() - n0); end
        checks++; if (ferr_cnt !== f0) begin failures++; $display("FAIL false_ferr: got %0d expected 0", ferr_cnt - f0); end
        checks++; if (bus.Rx_data !== 8'hA5) begin failures++; $display("FAIL false_data: got %0h expected a5", bus.Rx_data); end
    endtask

    task automatic test_bad_stop();
        int n0 = rx_q.size();
        int f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        #BIT;
        checks++; if (ferr_cnt !== f0 + 1) begin failures++; $display("FAIL badstop_ferr: got %0d expected 1", ferr_cnt - f0); end
        checks++; if (rx_q.size() !== n0) begin failures++; $display("FAIL badstop_valid: got %0d expected 0", rx_q.size() - n0); end
        checks++; if (bus.Rx_data !== 8'hA5) begin failures++; $display("FAIL badstop_data: got %0h expected a5", bus.Rx_data); end
        checks++; if (bus.Rx_busy !== 1'b0) begin failures++; $display("FAIL badstop_busy: got %0b expected 0", bus.Rx_busy); end
    endtask

    task automatic test_break();
        int n0 = rx_q.size();
        int f0 = ferr_cnt;
        bus.Rx = 1'b0;
        #(20 * BIT);
        bus.Rx = 1'b1;
        #BIT;
        checks++; if (ferr_cnt !== f0 + 1) begin failures++; $display("FAIL break_ferr: got %0d expected 1", ferr_cnt - f0); end
        checks++; if (bus.Rx_busy !== 1'b0) begin failures++; $display("FAIL break_busy: got %0b expected 0", bus.Rx_busy); end
        send_frame(8'h55, 1'b1);
        #BIT;
        checks++; if (rx_q.size() !== n0 + 1) begin failures++; $display("FAIL break_count: got %0d expected 1", rx_q.size() - n0); end
        checks++; if (bus.Rx_data !== 8'h55) begin failures++; $display("FAIL break_data: got %0h expected 55", bus.Rx_data); end
    endtask

    task automatic test_back_to_back();
        int n0 = rx_q.size();
        int f0 = ferr_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        #BIT;
        checks++; if (rx_q.size() !== n0 + 2) begin failures++; $display("FAIL b2b_count: got %0d expected 2", rx_q.size() - n0); end
        else begin
            checks++; if (rx_q[n0] !== 8'h00) begin failures++; $display("FAIL b2b_first: got %0h expected 00", rx_q[n0]); end
            checks++; if (rx_q[n0+1] !== 8'hFF) begin failures++; $display("FAIL b2b_second: got %0h expected ff", rx_q[n0+1]); end
        end
        checks++; if (ferr_cnt !== f0) begin failures++; $display("FAIL b2b_ferr: got %0d expected 0", ferr_cnt - f0); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b = 8'h81;
        int n0;
        bus.Rx = 1'b0;
        #BIT;
        for (int i = 0; i < 3; i++) begin
            bus.Rx = b[i];
            #BIT;
        end
        bus.Rx = b[3];
        #(BIT/2);
        checks++; if (bus.Rx_busy !== 1'b1) begin failures++; $display("FAIL mid_busy_pre: got %0b expected 1", bus.Rx_busy); end
        reset = 1'b1;
        #1;
        checks++; if (bus.Rx_data !== 8'h00) begin failures++; $display("FAIL mid_reset_data: got %0h expected 00", bus.Rx_data); end
        checks++; if (bus.Rx_busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %0b expected 0", bus.Rx_busy); end
        checks++; if (bus.Rx_valid !== 1'b0 || bus.Framing_error !== 1'b0) begin failures++; $display("FAIL mid_reset_pulses: got %0b%0b expected 00", bus.Rx_valid, bus.Framing_error); end
        bus.Rx = 1'b1;
        repeat (3) @(negedge Sys_clock);
        reset = 1'b0;
        #(2 * BIT);
        n0 = rx_q.size();
        send_frame(8'h81, 1'b1);
        #BIT;
        checks++; if (rx_q.size() !== n0 + 1) begin failures++; $display("FAIL mid_after_count: got %0d expected 1", rx_q.size() - n0); end
        checks++; if (bus.Rx_data !== 8'h81) begin failures++; $display("FAIL mid_after_data: got %0h expected 81", bus.Rx_data); end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int   exp_f = 0;
        int   n0 = rx_q.size();
        int   f0 = ferr_cnt;
        logic [7:0] b;
        logic ok;
        for (int k = 0; k < 14; k++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            send_frame(b, ok);
            if (ok) exp_q.push_back(b);
            else exp_f++;
            if (!ok) #(BIT/2 + $urandom_range(0, 2) * BIT/4);
            else     #($urandom_range(0, 3) * BIT/4);
        end
        #BIT;
        checks++; if (rx_q.size() - n0 !== exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d expected %0d", rx_q.size() - n0, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && (n0 + i) < rx_q.size(); i++) begin
            checks++; if (rx_q[n0+i] !== exp_q[i]) begin failures++; $display("FAIL rand_byte%0d: got %0h expected %0h", i, rx_q[n0+i], exp_q[i]); end
        end
        checks++; if (ferr_cnt - f0 !== exp_f) begin failures++; $display("FAIL rand_ferr: got %0d expected %0d", ferr_cnt - f0, exp_f); end
    endtask

    task automatic test_pulse_shape();
        checks++; if (width_err !== 0) begin failures++; $display("FAIL pulse_width: got %0d wide pulses expected 0", width_err); end
        checks++; if (excl_err !== 0) begin failures++; $display("FAIL pulse_excl: got %0d overlaps expected 0", excl_err); end
    endtask

    initial begin
        bus.Rx = 1'b1;
        test_reset();
        test_good_frame();
        test_false_start();
        test_bad_stop();
        test_break();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        test_pulse_shape();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
